// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_pkg
//
// Shared constants for the write-back stage and register file. Default bus
// widths, register count and the polarity encodings for reset, write enable and
// read enable. These were the old `defines.v` macros; they live here as
// typed localparams so every user gets them through one import.
//
// Contents:
//   RegBusW     default data width of a general-purpose register
//   RegAddrW    default register address width
//   RegNum      number of architectural registers (2^RegAddrW)
//   ZeroWord    all-zero value of the default data width
//   RstEnable   level of the active-low reset when asserted
//   WriteEnable / WriteDisable, ReadEnable / ReadDisable
//   reg_bus_t, reg_addr_t  default-width convenience types
// -----------------------------------------------------------------------------
package wb_regfile_pkg;

  localparam int unsigned RegBusW  = 32;
  localparam int unsigned RegAddrW = 5;
  localparam int unsigned RegNum   = 1 << RegAddrW;

  typedef logic [RegBusW-1:0]  reg_bus_t;
  typedef logic [RegAddrW-1:0] reg_addr_t;

  localparam reg_bus_t ZeroWord = '0;

  localparam logic RstEnable    = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

endpackage

// File: rtl/wb_regfile_gpr.sv
// -----------------------------------------------------------------------------
// wb_regfile_gpr  (general-purpose register array)
//
// Raw 2^ADDR_W x DATA_W storage. One synchronous write port and two
// asynchronous read ports. A synchronous active-low reset clears every entry
// and suppresses the write on that edge. No register-0 protection and no
// bypassing here; the parent owns both.
//
// Ports:
//   clk        clock, all updates on the rising edge
//   rst        synchronous reset, active-low
//   we_i       write enable
//   waddr_i    write address
//   wdata_i    write data
//   raddr1_i   read address, port 1
//   raddr2_i   read address, port 2
//   rdata1_o   raw array contents at raddr1_i
//   rdata2_o   raw array contents at raddr2_i
// -----------------------------------------------------------------------------
module wb_regfile_gpr
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RegBusW,
  parameter int unsigned ADDR_W = RegAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [Depth];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we_i == WriteEnable) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = r_mem[raddr1_i];
  assign rdata2_o = r_mem[raddr2_i];

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//
// Write-back stage plus general-purpose register file. The execute result
// (data, destination, write enable) is captured in a stallable/flushable latch;
// the latched result is committed to the register array on the following edge.
// Two combinational read ports serve decode, bypassing first from the incoming
// execute result and then from the latched result. Register 0 reads as zero
// and is never written.
//
// Ports:
//   clk                   clock, all state updates on the rising edge
//   rst                   synchronous reset, active-low
//   stall_i               hold the write-back latch
//   flush_i               clear the write-back latch (wins over stall)
//   ex_wdata_i            execute-stage result data
//   ex_wd_i               execute-stage destination register
//   ex_wreg_i             execute-stage write enable
//   re1_i, re2_i          read-port enables
//   raddr1_i, raddr2_i    read-port addresses
//   rdata1_o, rdata2_o    read data (combinational)
//   wb_wdata_o            latched data
//   wb_wd_o               latched destination
//   wb_wreg_o             latched write enable
// -----------------------------------------------------------------------------
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_W = RegBusW,
  parameter int unsigned ADDR_W = RegAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic [ADDR_W-1:0] ex_wd_i,
  input  logic              ex_wreg_i,
  input  logic              re1_i,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o
);

  // ---------------------------------------------------------------------------
  // Write-back latch
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_wb_wdata;
  logic [ADDR_W-1:0] r_wb_wd;
  logic              r_wb_wreg;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_wb_wdata <= '0;
      r_wb_wd    <= '0;
      r_wb_wreg  <= WriteDisable;
    end else if (flush_i) begin
      r_wb_wdata <= '0;
      r_wb_wd    <= '0;
      r_wb_wreg  <= WriteDisable;
    end else if (!stall_i) begin
      r_wb_wdata <= ex_wdata_i;
      r_wb_wd    <= ex_wd_i;
      r_wb_wreg  <= ex_wreg_i;
    end
  end

  assign wb_wdata_o = r_wb_wdata;
  assign wb_wd_o    = r_wb_wd;
  assign wb_wreg_o  = r_wb_wreg;

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  // Commit uses the pre-edge latch contents, so it is independent of stall and
  // flush: a flush only drops the entry arriving from execute. Under stall the
  // same entry is rewritten each cycle with the same value.
  logic              w_arr_we;
  logic [DATA_W-1:0] w_arr_rdata1;
  logic [DATA_W-1:0] w_arr_rdata2;

  assign w_arr_we = (r_wb_wreg == WriteEnable) && (r_wb_wd != '0);

  wb_regfile_gpr #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_gpr (
    .clk      (clk),
    .rst      (rst),
    .we_i     (w_arr_we),
    .waddr_i  (r_wb_wd),
    .wdata_i  (r_wb_wdata),
    .raddr1_i (raddr1_i),
    .raddr2_i (raddr2_i),
    .rdata1_o (w_arr_rdata1),
    .rdata2_o (w_arr_rdata2)
  );

  // ---------------------------------------------------------------------------
  // Read ports: zero guard, then execute bypass, then latch bypass, then array
  // ---------------------------------------------------------------------------
  logic w_ex_hit1, w_ex_hit2;
  logic w_wb_hit1, w_wb_hit2;

  assign w_ex_hit1 = (ex_wreg_i == WriteEnable) && (ex_wd_i == raddr1_i);
  assign w_ex_hit2 = (ex_wreg_i == WriteEnable) && (ex_wd_i == raddr2_i);
  assign w_wb_hit1 = (r_wb_wreg == WriteEnable) && (r_wb_wd == raddr1_i);
  assign w_wb_hit2 = (r_wb_wreg == WriteEnable) && (r_wb_wd == raddr2_i);

  always_comb begin
    rdata1_o = '0;
    if ((rst == RstEnable) || (re1_i == ReadDisable) || (raddr1_i == '0)) begin
      rdata1_o = '0;
    end else if (w_ex_hit1) begin
      rdata1_o = ex_wdata_i;
    end else if (w_wb_hit1) begin
      rdata1_o = r_wb_wdata;
    end else begin
      rdata1_o = w_arr_rdata1;
    end
  end

  always_comb begin
    rdata2_o = '0;
    if ((rst == RstEnable) || (re2_i == ReadDisable) || (raddr2_i == '0)) begin
      rdata2_o = '0;
    end else if (w_ex_hit2) begin
      rdata2_o = ex_wdata_i;
    end else if (w_wb_hit2) begin
      rdata2_o = r_wb_wdata;
    end else begin
      rdata2_o = w_arr_rdata2;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i;
  logic [31:0] ex_wdata_i;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic        re1_i, re2_i;
  logic [4:0]  raddr1_i, raddr2_i;
  logic [31:0] rdata1_o, rdata2_o;
  logic [31:0] wb_wdata_o;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_regfile #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .ex_wdata_i (ex_wdata_i),
    .ex_wd_i    (ex_wd_i),
    .ex_wreg_i  (ex_wreg_i),
    .re1_i      (re1_i),
    .re2_i      (re2_i),
    .raddr1_i   (raddr1_i),
    .raddr2_i   (raddr2_i),
    .rdata1_o   (rdata1_o),
    .rdata2_o   (rdata2_o),
    .wb_wdata_o (wb_wdata_o),
    .wb_wd_o    (wb_wd_o),
    .wb_wreg_o  (wb_wreg_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic we, input logic [4:0] wd, input logic [31:0] d);
    ex_wreg_i  = we;
    ex_wd_i    = wd;
    ex_wdata_i = d;
  endtask

  initial begin
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    set_ex(1'b0, 5'd0, 32'h0);
    re1_i = 1'b1; re2_i = 1'b1; raddr1_i = 5'd1; raddr2_i = 5'd2;

    // Reset held two cycles with random inputs
    for (int i = 0; i < 2; i++) begin
      tick();
      set_ex(1'b1, 5'($urandom_range(1, 31)), $urandom);
      stall_i  = 1'($urandom);
      flush_i  = 1'b0;
      raddr1_i = ex_wd_i;
      raddr2_i = 5'($urandom_range(1, 31));
      #1;
      check_eq("rst_wb_wreg", {31'd0, wb_wreg_o}, 32'h0);
      check_eq("rst_wb_wd", {27'd0, wb_wd_o}, 32'h0);
      check_eq("rst_wb_wdata", wb_wdata_o, 32'h0);
      check_eq("rst_rdata1", rdata1_o, 32'h0);
      check_eq("rst_rdata2", rdata2_o, 32'h0);
    end
    tick();
    set_ex(1'b0, 5'd0, 32'h0);
    stall_i = 1'b0;
    rst     = 1'b1;
    for (int r = 1; r < 32; r++) begin
      raddr1_i = 5'(r);
      raddr2_i = 5'(32 - r);
      #1;
      check_eq($sformatf("post_rst_r%0d", r), rdata1_o | rdata2_o, 32'h0);
    end
    tick();

    // Bypass chain: EX, then latch, then array
    set_ex(1'b1, 5'd5, 32'h1234_5678);
    raddr1_i = 5'd5;
    #1;
    check_eq("chain_ex", rdata1_o, 32'h1234_5678);
    tick();
    set_ex(1'b0, 5'd0, 32'h0);
    #1;
    check_eq("chain_wb", rdata1_o, 32'h1234_5678);
    check_eq("chain_wb_wd", {27'd0, wb_wd_o}, 32'd5);
    check_eq("chain_wb_wreg", {31'd0, wb_wreg_o}, 32'd1);
    tick();
    check_eq("chain_arr", rdata1_o, 32'h1234_5678);
    check_eq("chain_idle_wreg", {31'd0, wb_wreg_o}, 32'd0);

    // Register 0 stays zero through every stage
    set_ex(1'b1, 5'd0, 32'hFFFF_FFFF);
    raddr1_i = 5'd0; raddr2_i = 5'd0;
    #1;
    check_eq("r0_ex_p1", rdata1_o, 32'h0);
    check_eq("r0_ex_p2", rdata2_o, 32'h0);
    tick();
    set_ex(1'b0, 5'd0, 32'h0);
    #1;
    check_eq("r0_wb_p1", rdata1_o, 32'h0);
    check_eq("r0_wb_p2", rdata2_o, 32'h0);
    check_eq("r0_wb_wdata", wb_wdata_o, 32'hFFFF_FFFF);
    tick();
    check_eq("r0_arr_p1", rdata1_o, 32'h0);
    check_eq("r0_arr_p2", rdata2_o, 32'h0);
    raddr1_i = 5'd5;
    #1;
    check_eq("r0_r5_intact", rdata1_o, 32'h1234_5678);

    // Stall: latch holds old entry, EX bypass returns the new one
    set_ex(1'b1, 5'd3, 32'h0000_000A);
    raddr1_i = 5'd3;
    tick();
    stall_i = 1'b1;
    set_ex(1'b1, 5'd3, 32'h0000_000B);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("stall%0d_wb_wdata", i), wb_wdata_o, 32'h0000_000A);
      check_eq($sformatf("stall%0d_rd", i), rdata1_o, 32'h0000_000B);
      tick();
    end
    stall_i = 1'b0;
    #1;
    check_eq("stall_rel_rd", rdata1_o, 32'h0000_000B);
    tick();
    set_ex(1'b0, 5'd0, 32'h0);
    #1;
    check_eq("stall_rel_wb_wdata", wb_wdata_o, 32'h0000_000B);
    check_eq("stall_rel_wb_rd", rdata1_o, 32'h0000_000B);
    tick();
    check_eq("stall_rel_arr_rd", rdata1_o, 32'h0000_000B);

    // Flush with stall: latched r7 commits, incoming r8 is dropped
    set_ex(1'b1, 5'd7, 32'h0000_0055);
    tick();
    flush_i = 1'b1; stall_i = 1'b1;
    set_ex(1'b1, 5'd8, 32'h0000_0066);
    tick();
    flush_i = 1'b0; stall_i = 1'b0;
    set_ex(1'b0, 5'd0, 32'h0);
    raddr1_i = 5'd7; raddr2_i = 5'd8;
    #1;
    check_eq("flush_wb_wreg", {31'd0, wb_wreg_o}, 32'd0);
    check_eq("flush_wb_wd", {27'd0, wb_wd_o}, 32'd0);
    check_eq("flush_wb_wdata", wb_wdata_o, 32'h0);
    check_eq("flush_r7", rdata1_o, 32'h0000_0055);
    check_eq("flush_r8", rdata2_o, 32'h0);
    tick();
    check_eq("flush_r8_later", rdata2_o, 32'h0);

    // Read enables and port independence
    set_ex(1'b1, 5'd9, 32'h0000_0099);
    re2_i = 1'b0; raddr2_i = 5'd9; raddr1_i = 5'd9;
    #1;
    check_eq("re2_off", rdata2_o, 32'h0);
    check_eq("re1_on_ex", rdata1_o, 32'h0000_0099);
    re2_i = 1'b1; raddr1_i = 5'd5; raddr2_i = 5'd5;
    #1;
    check_eq("same_addr_p1", rdata1_o, 32'h1234_5678);
    check_eq("same_addr_p2", rdata2_o, 32'h1234_5678);
    tick();
    set_ex(1'b0, 5'd0, 32'h0);

    // Reset mid-stream: pending r9 is discarded and the array is cleared
    rst = 1'b0;
    raddr2_i = 5'd9;
    #1;
    check_eq("midrst_rd_low", rdata1_o, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    check_eq("midrst_wb_wreg", {31'd0, wb_wreg_o}, 32'd0);
    check_eq("midrst_wb_wdata", wb_wdata_o, 32'h0);
    check_eq("midrst_r5", rdata1_o, 32'h0);
    check_eq("midrst_r9", rdata2_o, 32'h0);
    tick();
    check_eq("midrst_r9_later", rdata2_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
